// File: rtl/fb_page_ctrl_if.sv
// Bundle of the page-scheduler signals: writer/scanout event pulses in,
// page selections, base addresses, stall, swap pulse and statistics out.
//
// Handshake semantics: this block has no valid/ready pairs. wr_frame_done and
// rd_vblank are single-cycle event strobes that are sampled on every rising
// clock edge and never back-pressured. The source deasserts each strobe after
// one cycle. All outputs are registered and valid every cycle. Writer-side
// back-pressure is expressed only through wr_stall, which is used in double mode.
interface fb_page_ctrl_if #(
  parameter int ADDR_W = 18
);
  logic              wr_frame_done;
  logic              rd_vblank;
  logic [1:0]        wr_page;
  logic [1:0]        rd_page;
  logic [ADDR_W-1:0] wr_base;
  logic [ADDR_W-1:0] rd_base;
  logic              wr_stall;
  logic              swap_pulse;
  logic [7:0]        drop_count;
  logic [7:0]        repeat_count;
  logic              dbg_pending;   // FSM state: 1 = PENDING (ready frame held)

  // Event source: the writer and scanout side.
  modport master (
    output wr_frame_done, rd_vblank,
    input  wr_page, rd_page, wr_base, rd_base, wr_stall, swap_pulse,
           drop_count, repeat_count, dbg_pending
  );

  // Page controller.
  modport slave (
    input  wr_frame_done, rd_vblank,
    output wr_page, rd_page, wr_base, rd_base, wr_stall, swap_pulse,
           drop_count, repeat_count, dbg_pending
  );
endinterface

// File: rtl/fb_page_ctrl.sv
// Tear-free framebuffer page scheduler. A completed frame is handed to scanout
// only at vblank. Triple buffering lets the writer keep running and overwrites
// an undisplayed frame, which is counted as a drop. Double buffering stalls the
// writer until the swap. Vblanks with no new frame are counted as repeats.
module fb_page_ctrl #(
  parameter int NUM_PAGES  = 3,
  parameter int PAGE_WORDS = 61440,
  parameter int ADDR_W     = 18
) (
  input logic          clk,
  input logic          reset,
  fb_page_ctrl_if.slave bus
);

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1   // a completed frame waits for vblank (WAIT_SWAP in double mode)
  } state_t;

  state_t            r_state,      w_nxt_state;
  logic [1:0]        r_wr_page,    w_nxt_wr_page;
  logic [1:0]        r_rd_page,    w_nxt_rd_page;
  logic [1:0]        r_ready_page, w_nxt_ready_page;
  logic [ADDR_W-1:0] r_wr_base;
  logic [ADDR_W-1:0] r_rd_base;
  logic              r_wr_stall,   w_nxt_wr_stall;
  logic              r_swap_pulse, w_nxt_swap_pulse;
  logic [7:0]        r_drop_cnt,   w_nxt_drop_cnt;
  logic [7:0]        r_repeat_cnt, w_nxt_repeat_cnt;
  logic [1:0]        w_third_page;
  logic              w_fd;
  logic              w_vb;

  // Base address of a page. Page 3 never occurs, so it maps to zero.
  function automatic logic [ADDR_W-1:0] page_base(input logic [1:0] page);
    case (page)
      2'd1:    page_base = ADDR_W'(PAGE_WORDS);
      2'd2:    page_base = ADDR_W'(2 * PAGE_WORDS);
      default: page_base = '0;
    endcase
  endfunction

  // Saturating statistics counter that holds at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_fd = bus.wr_frame_done;
  assign w_vb = bus.rd_vblank;

  // Pages are 0..2 and wr/rd always differ, so 3 - rd - wr is the remaining page.
  assign w_third_page = 2'd3 - r_rd_page - r_wr_page;

  // State register and all registered outputs. Reset wins over any pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= EMPTY;
      r_wr_page    <= 2'd1;
      r_rd_page    <= 2'd0;
      r_ready_page <= 2'd2;
      r_wr_base    <= ADDR_W'(PAGE_WORDS);
      r_rd_base    <= '0;
      r_wr_stall   <= 1'b0;
      r_swap_pulse <= 1'b0;
      r_drop_cnt   <= 8'd0;
      r_repeat_cnt <= 8'd0;
    end else begin
      r_state      <= w_nxt_state;
      r_wr_page    <= w_nxt_wr_page;
      r_rd_page    <= w_nxt_rd_page;
      r_ready_page <= w_nxt_ready_page;
      r_wr_base    <= page_base(w_nxt_wr_page);
      r_rd_base    <= page_base(w_nxt_rd_page);
      r_wr_stall   <= w_nxt_wr_stall;
      r_swap_pulse <= w_nxt_swap_pulse;
      r_drop_cnt   <= w_nxt_drop_cnt;
      r_repeat_cnt <= w_nxt_repeat_cnt;
    end
  end

  // Next-state and next-output logic for both buffering depths.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_wr_page    = r_wr_page;
    w_nxt_rd_page    = r_rd_page;
    w_nxt_ready_page = r_ready_page;
    w_nxt_wr_stall   = r_wr_stall;
    w_nxt_swap_pulse = 1'b0;
    w_nxt_drop_cnt   = r_drop_cnt;
    w_nxt_repeat_cnt = r_repeat_cnt;

    if (NUM_PAGES == 3) begin
      // Completing a frame while one is still pending overwrites it.
      if (w_fd && r_state == PENDING) begin
        w_nxt_drop_cnt = sat_inc(r_drop_cnt);
      end
      if (w_fd && w_vb) begin
        // The completed frame goes straight to scanout. The writer moves to the
        // third page, and the old scanout page becomes the spare.
        w_nxt_rd_page    = r_wr_page;
        w_nxt_wr_page    = w_third_page;
        w_nxt_ready_page = r_rd_page;
        w_nxt_swap_pulse = 1'b1;
        w_nxt_state      = EMPTY;
      end else if (w_fd) begin
        w_nxt_ready_page = r_wr_page;
        w_nxt_wr_page    = w_third_page;
        w_nxt_state      = PENDING;
      end else if (w_vb) begin
        if (r_state == PENDING) begin
          w_nxt_rd_page    = r_ready_page;
          w_nxt_ready_page = r_rd_page;
          w_nxt_swap_pulse = 1'b1;
          w_nxt_state      = EMPTY;
        end else begin
          w_nxt_repeat_cnt = sat_inc(r_repeat_cnt);
        end
      end
    end else begin
      // Double mode: a frame_done while already waiting is a protocol violation.
      // The pulse is dropped and counted.
      if (w_fd && r_state == PENDING) begin
        w_nxt_drop_cnt = sat_inc(r_drop_cnt);
      end
      if (w_vb) begin
        if (r_state == PENDING || w_fd) begin
          w_nxt_rd_page    = r_wr_page;
          w_nxt_wr_page    = r_rd_page;
          w_nxt_wr_stall   = 1'b0;
          w_nxt_swap_pulse = 1'b1;
          w_nxt_state      = EMPTY;
        end else begin
          w_nxt_repeat_cnt = sat_inc(r_repeat_cnt);
        end
      end else if (w_fd && r_state == EMPTY) begin
        w_nxt_wr_stall = 1'b1;
        w_nxt_state    = PENDING;
      end
    end
  end

  assign bus.wr_page      = r_wr_page;
  assign bus.rd_page      = r_rd_page;
  assign bus.wr_base      = r_wr_base;
  assign bus.rd_base      = r_rd_base;
  assign bus.wr_stall     = r_wr_stall;
  assign bus.swap_pulse   = r_swap_pulse;
  assign bus.drop_count   = r_drop_cnt;
  assign bus.repeat_count = r_repeat_cnt;
  assign bus.dbg_pending  = (r_state == PENDING);

endmodule

// File: tb/tb_fb_page_ctrl.sv
// Directed bench for fb_page_ctrl. It drives a triple-buffered and a
// double-buffered instance from one clock and one reset, and checks them
// against hand-computed values.
module tb_fb_page_ctrl;

  localparam int PW = 61440;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  fb_page_ctrl_if #(.ADDR_W(18)) if3 ();
  fb_page_ctrl_if #(.ADDR_W(18)) if2 ();

  fb_page_ctrl #(.NUM_PAGES(3), .PAGE_WORDS(PW), .ADDR_W(18)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  fb_page_ctrl #(.NUM_PAGES(2), .PAGE_WORDS(PW), .ADDR_W(18)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Drivers: inputs change on the falling edge. After a task returns we sit at
  // the next falling edge, one rising edge after the pulse was sampled.
  task automatic pulse3(input logic fd, input logic vb);
    @(negedge clk);
    if3.wr_frame_done = fd;
    if3.rd_vblank     = vb;
    @(negedge clk);
    if3.wr_frame_done = 1'b0;
    if3.rd_vblank     = 1'b0;
  endtask

  task automatic pulse2(input logic fd, input logic vb);
    @(negedge clk);
    if2.wr_frame_done = fd;
    if2.rd_vblank     = vb;
    @(negedge clk);
    if2.wr_frame_done = 1'b0;
    if2.rd_vblank     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    if3.wr_frame_done = 1'b0;
    if3.rd_vblank     = 1'b0;
    if2.wr_frame_done = 1'b0;
    if2.rd_vblank     = 1'b0;
    do_reset();

    // Reset values
    chk("rst3_wr_page", 32'(if3.wr_page), 1);
    chk("rst3_rd_page", 32'(if3.rd_page), 0);
    chk("rst3_wr_base", 32'(if3.wr_base), PW);
    chk("rst3_rd_base", 32'(if3.rd_base), 0);
    chk("rst3_stall",   32'(if3.wr_stall), 0);
    chk("rst3_swap",    32'(if3.swap_pulse), 0);
    chk("rst3_drop",    32'(if3.drop_count), 0);
    chk("rst3_repeat",  32'(if3.repeat_count), 0);
    chk("rst3_state",   32'(if3.dbg_pending), 0);
    chk("rst2_wr_page", 32'(if2.wr_page), 1);
    chk("rst2_rd_page", 32'(if2.rd_page), 0);

    // T1: one frame, then vblank
    pulse3(1'b1, 1'b0);
    chk("t1_fd_wr_page", 32'(if3.wr_page), 2);
    chk("t1_fd_rd_page", 32'(if3.rd_page), 0);
    chk("t1_fd_wr_base", 32'(if3.wr_base), 2 * PW);
    chk("t1_fd_state",   32'(if3.dbg_pending), 1);
    pulse3(1'b0, 1'b1);
    chk("t1_vb_rd_page", 32'(if3.rd_page), 1);
    chk("t1_vb_swap",    32'(if3.swap_pulse), 1);
    chk("t1_vb_rd_base", 32'(if3.rd_base), PW);
    chk("t1_vb_wr_page", 32'(if3.wr_page), 2);
    @(negedge clk);
    chk("t1_swap_low",   32'(if3.swap_pulse), 0);

    // T2: rd=1 wr=2. Two frames with no vblank, so the first one is dropped.
    pulse3(1'b1, 1'b0);
    chk("t2_fd1_wr_page", 32'(if3.wr_page), 0);
    pulse3(1'b1, 1'b0);
    chk("t2_fd2_drop",    32'(if3.drop_count), 1);
    chk("t2_fd2_wr_page", 32'(if3.wr_page), 2);
    chk("t2_fd2_rd_page", 32'(if3.rd_page), 1);
    pulse3(1'b0, 1'b1);
    chk("t2_vb_rd_page",  32'(if3.rd_page), 0);
    chk("t2_vb_swap",     32'(if3.swap_pulse), 1);
    chk("t2_vb_wr_page",  32'(if3.wr_page), 2);

    // T3: three vblanks with nothing pending
    pulse3(1'b0, 1'b1);
    chk("t3_swap1",   32'(if3.swap_pulse), 0);
    pulse3(1'b0, 1'b1);
    chk("t3_swap2",   32'(if3.swap_pulse), 0);
    pulse3(1'b0, 1'b1);
    chk("t3_swap3",   32'(if3.swap_pulse), 0);
    chk("t3_repeat",  32'(if3.repeat_count), 3);
    chk("t3_rd_page", 32'(if3.rd_page), 0);

    // T4: frame_done and vblank together, starting from reset
    do_reset();
    chk("t4_rst_repeat", 32'(if3.repeat_count), 0);
    chk("t4_rst_drop",   32'(if3.drop_count), 0);
    pulse3(1'b1, 1'b1);
    chk("t4_rd_page", 32'(if3.rd_page), 1);
    chk("t4_wr_page", 32'(if3.wr_page), 2);
    chk("t4_swap",    32'(if3.swap_pulse), 1);
    chk("t4_drop",    32'(if3.drop_count), 0);
    chk("t4_repeat",  32'(if3.repeat_count), 0);
    chk("t4_state",   32'(if3.dbg_pending), 0);

    // T5: double buffering, including a protocol-violating second frame_done
    pulse2(1'b1, 1'b0);
    chk("t5_fd_stall",   32'(if2.wr_stall), 1);
    chk("t5_fd_state",   32'(if2.dbg_pending), 1);
    chk("t5_fd_wr_page", 32'(if2.wr_page), 1);
    pulse2(1'b1, 1'b0);
    chk("t5_fd2_drop",   32'(if2.drop_count), 1);
    chk("t5_fd2_stall",  32'(if2.wr_stall), 1);
    pulse2(1'b0, 1'b1);
    chk("t5_vb_rd_page", 32'(if2.rd_page), 1);
    chk("t5_vb_wr_page", 32'(if2.wr_page), 0);
    chk("t5_vb_stall",   32'(if2.wr_stall), 0);
    chk("t5_vb_swap",    32'(if2.swap_pulse), 1);
    chk("t5_vb_wr_base", 32'(if2.wr_base), 0);
    chk("t5_vb_rd_base", 32'(if2.rd_base), PW);
    pulse2(1'b1, 1'b1);
    chk("t5_both_rd_page", 32'(if2.rd_page), 0);
    chk("t5_both_wr_page", 32'(if2.wr_page), 1);
    chk("t5_both_stall",   32'(if2.wr_stall), 0);
    chk("t5_both_swap",    32'(if2.swap_pulse), 1);
    chk("t5_both_repeat",  32'(if2.repeat_count), 0);
    pulse2(1'b0, 1'b1);
    chk("t5_rep_repeat",   32'(if2.repeat_count), 1);

    // T6: vblank held for 300 cycles saturates the repeat counter
    @(negedge clk);
    if3.rd_vblank = 1'b1;
    repeat (300) @(negedge clk);
    if3.rd_vblank = 1'b0;
    chk("t6_repeat_sat", 32'(if3.repeat_count), 255);
    chk("t6_swap",       32'(if3.swap_pulse), 0);
    pulse3(1'b1, 1'b0);
    chk("t6_pending",    32'(if3.dbg_pending), 1);
    // Reset for one cycle while both pulses are also asserted
    @(negedge clk);
    reset = 1'b1;
    if3.wr_frame_done = 1'b1;
    if3.rd_vblank     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    if3.wr_frame_done = 1'b0;
    if3.rd_vblank     = 1'b0;
    chk("t6_rst_wr_page", 32'(if3.wr_page), 1);
    chk("t6_rst_rd_page", 32'(if3.rd_page), 0);
    chk("t6_rst_wr_base", 32'(if3.wr_base), PW);
    chk("t6_rst_rd_base", 32'(if3.rd_base), 0);
    chk("t6_rst_swap",    32'(if3.swap_pulse), 0);
    chk("t6_rst_drop",    32'(if3.drop_count), 0);
    chk("t6_rst_repeat",  32'(if3.repeat_count), 0);
    chk("t6_rst_state",   32'(if3.dbg_pending), 0);
    chk("t6_rst2_stall",  32'(if2.wr_stall), 0);
    chk("t6_rst2_repeat", 32'(if2.repeat_count), 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
